// File: rtl/scalar_writeback_arbiter_pkg.sv
// Shared types for the scalar register-file write port: register address,
// result data and the queued write-back entry.
package scalar_writeback_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_W-1:0]  scalar_reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        scalar_reg_addr_t rd;
        data_t            data;
    } wb_entry_t;

    localparam scalar_reg_addr_t SCALAR_ZERO_REG = '0;

    // One-hot scoreboard bit for a register; r0 never occupies a bit.
    function automatic logic [NUM_REGS-1:0] reg_bit(input scalar_reg_addr_t r);
        return (r == SCALAR_ZERO_REG) ? '0 : (NUM_REGS'(1) << r);
    endfunction

endpackage

// File: rtl/scalar_writeback_arbiter_fifo.sv
// Small circular buffer holding LSU results that lost arbitration to the ALU.
module wb_result_fifo
    import scalar_writeback_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push lands in, so push is legal when full.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Merges ALU and LSU scalar results into one registered write-back stream and
// tracks outstanding writes so issue can stall on RAW/WAW hazards.
module scalar_writeback_arbiter
    import scalar_writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_write_enable,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    output logic                  issue_stall,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  wb_enable,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [31:0]           pending_mask,
    output logic                  idle
);

    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

    wb_entry_t        alu_entry, lsu_entry, fifo_head, sel;
    logic             sel_valid, sel_write, pop, bypass, push;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             issue_accept;
    logic [31:0]      set_mask, clr_mask;

    assign alu_entry = '{rd: alu_rd, data: data_t'(alu_data)};
    assign lsu_entry = '{rd: lsu_rd, data: data_t'(lsu_data)};

    wb_result_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (lsu_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ALU has no backpressure so it always wins; queued LSU results drain
    // before a fresh LSU result may bypass the queue.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        pop       = 1'b0;
        bypass    = 1'b0;
        if (alu_valid) begin
            sel       = alu_entry;
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel       = fifo_head;
            sel_valid = 1'b1;
            pop       = 1'b1;
        end else if (lsu_valid) begin
            sel       = lsu_entry;
            sel_valid = 1'b1;
            bypass    = 1'b1;
        end
    end

    assign lsu_ready = ~fifo_full;
    assign push      = lsu_valid & lsu_ready & ~bypass;
    assign sel_write = sel_valid & (sel.rd != SCALAR_ZERO_REG);

    assign issue_stall  = issue_valid & (pending_mask[issue_rs1] | pending_mask[issue_rs2] |
                                         (issue_write_enable & pending_mask[issue_rd]));
    assign issue_accept = issue_valid & ~issue_stall;
    assign set_mask     = (issue_accept & issue_write_enable) ? reg_bit(issue_rd) : '0;
    assign clr_mask     = sel_write ? reg_bit(sel.rd) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_enable    <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            pending_mask <= '0;
        end else begin
            wb_enable <= sel_write;
            if (sel_write) begin
                wb_rd   <= sel.rd;
                wb_data <= DATA_WIDTH'(sel.data);
            end
            // A new issue to the same rd must stay pending, so set wins.
            pending_mask <= (pending_mask & ~clr_mask) | set_mask;
        end
    end

    assign idle = (fifo_count == '0) & (pending_mask == '0) & ~wb_enable;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && sel_write && !pending_mask[sel.rd])
            $warning("scalar write-back to r%0d with no pending write", sel.rd);
    end
`endif

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Directed plus randomized checks of the scalar write-back arbiter against a
// queue-based reference model.
module tb_scalar_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_write_enable;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        wb_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pending_mask;
    logic        idle;

    scalar_writeback_arbiter #(.DATA_WIDTH(32), .LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_write_enable(issue_write_enable),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending_mask(pending_mask), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

    ent_t        q[$];
    logic [31:0] m_pend;
    bit          m_wb_en;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    bit          last_acc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend    = '0;
        m_wb_en   = 0;
        m_wb_rd   = '0;
        m_wb_data = '0;
        last_acc  = 1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_write_enable = 0;
        issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    endtask

    // One clock with the currently driven inputs: check combinational outputs,
    // advance the model, cross the edge, check registered outputs.
    task automatic cycle();
        int   sz;
        bit   stall, acc, sv, byp;
        ent_t sel;
        #1;
        sz    = q.size();
        stall = issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] ||
                                (issue_write_enable && m_pend[issue_rd]));
        chk("issue_stall", 32'(issue_stall), 32'(stall));
        chk("lsu_ready", 32'(lsu_ready), 32'(sz < DEPTH));
        chk("idle", 32'(idle), 32'(sz == 0 && m_pend == 0 && !m_wb_en));
        sv = 0; byp = 0; sel.rd = '0; sel.data = '0;
        if (alu_valid) begin
            sel.rd = alu_rd; sel.data = alu_data; sv = 1;
        end else if (sz > 0) begin
            sel = q.pop_front(); sv = 1;
        end else if (lsu_valid) begin
            sel.rd = lsu_rd; sel.data = lsu_data; sv = 1; byp = 1;
        end
        last_acc = lsu_valid && (sz < DEPTH);
        if (last_acc && !byp) q.push_back('{lsu_rd, lsu_data});
        acc     = issue_valid && !stall;
        m_wb_en = sv && (sel.rd != 0);
        if (m_wb_en) begin
            m_wb_rd   = sel.rd;
            m_wb_data = sel.data;
            m_pend[sel.rd] = 1'b0;
        end
        if (acc && issue_write_enable && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("wb_enable", 32'(wb_enable), 32'(m_wb_en));
        chk("pending_mask", pending_mask, m_pend);
        if (m_wb_en) begin
            chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
            chk("wb_data", wb_data, m_wb_data);
        end
    endtask

    // Asynchronous reset pulse starting mid-cycle (edge + 1).
    task automatic do_reset();
        reset = 1;
        #1;
        chk("rst wb_enable", 32'(wb_enable), 32'd0);
        chk("rst pending_mask", pending_mask, 32'd0);
        chk("rst idle", 32'(idle), 32'd1);
        chk("rst lsu_ready", 32'(lsu_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int k;
        clear_inputs();
        model_reset();
        reset = 1;
        #2;
        chk("reset wb_enable", 32'(wb_enable), 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset pending_mask", pending_mask, 32'd0);
        chk("reset lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset issue_stall", 32'(issue_stall), 32'd0);
        chk("reset idle", 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        reset = 0;

        // 1: issue rd5, ALU writes it back and clears the pending bit
        issue_valid = 1; issue_write_enable = 1; issue_rd = 5'd5;
        cycle();
        chk("t1 pending5 set", 32'(pending_mask[5]), 32'd1);
        clear_inputs();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
        cycle();
        chk("t1 wb_enable", 32'(wb_enable), 32'd1);
        chk("t1 wb_rd", 32'(wb_rd), 32'd5);
        chk("t1 wb_data", wb_data, 32'h1234);
        chk("t1 pending5 clr", 32'(pending_mask[5]), 32'd0);

        // 2: RAW stall on r7 until its write-back edge
        clear_inputs();
        issue_valid = 1; issue_write_enable = 1; issue_rd = 5'd7;
        cycle();
        issue_write_enable = 0; issue_rd = 5'd0; issue_rs1 = 5'd7;
        #1 chk("t2 stall held", 32'(issue_stall), 32'd1);
        cycle();
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
        #1 chk("t2 stall at wb", 32'(issue_stall), 32'd1);
        cycle();
        alu_valid = 0;
        #1 chk("t2 stall released", 32'(issue_stall), 32'd0);
        cycle();

        // 3: ALU and LSU collide with an empty queue
        clear_inputs();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h3333;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h4444;
        #1 chk("t3 lsu_ready", 32'(lsu_ready), 32'd1);
        cycle();
        chk("t3 first rd", 32'(wb_rd), 32'd3);
        clear_inputs();
        cycle();
        chk("t3 second rd", 32'(wb_rd), 32'd4);
        chk("t3 second data", wb_data, 32'h4444);

        // 4: sustained ALU traffic fills the LSU queue, then drains in order
        k = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hB000 + 32'(i);
            lsu_valid = 1; lsu_rd = 5'(20 + k); lsu_data = 32'hA000 + 32'(k);
            if (i >= 4) begin
                #1 chk("t4 lsu_ready low", 32'(lsu_ready), 32'd0);
            end
            cycle();
            if (last_acc) k++;
        end
        clear_inputs();
        for (int j = 0; j < 4; j++) begin
            cycle();
            chk("t4 drain rd", 32'(wb_rd), 32'(20 + j));
            chk("t4 drain data", wb_data, 32'hA000 + 32'(j));
        end
        cycle();
        chk("t4 idle", 32'(idle), 32'd1);

        // 5: LSU result to r0 is consumed silently
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
        #1 chk("t5 lsu_ready", 32'(lsu_ready), 32'd1);
        cycle();
        chk("t5 wb_enable", 32'(wb_enable), 32'd0);
        chk("t5 pending", pending_mask, 32'd0);
        clear_inputs();
        cycle();

        // 6: reset with queued entries and pending bits
        issue_valid = 1; issue_write_enable = 1; issue_rd = 5'd3;
        cycle();
        issue_rd = 5'd4;
        cycle();
        clear_inputs();
        alu_valid = 1; alu_rd = 5'd9;  alu_data = 32'h9;
        lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC;
        cycle();
        alu_rd = 5'd10; lsu_rd = 5'd13; lsu_data = 32'hD;
        cycle();
        chk("t6 pending before", pending_mask, 32'h18);
        clear_inputs();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("t6 no stale write", 32'(wb_enable), 32'd0);
        end

        // Randomized traffic with LSU valid/ready handshake
        for (int i = 0; i < 400; i++) begin
            issue_valid        = ($urandom_range(99) < 60);
            issue_write_enable = ($urandom_range(99) < 70);
            issue_rd  = 5'($urandom_range(7));
            issue_rs1 = 5'($urandom_range(7));
            issue_rs2 = 5'($urandom_range(7));
            alu_valid = ($urandom_range(99) < 35);
            alu_rd    = 5'($urandom_range(7));
            alu_data  = $urandom;
            if (!lsu_valid || last_acc) begin
                lsu_valid = ($urandom_range(99) < 55);
                lsu_rd    = 5'($urandom_range(7));
                lsu_data  = $urandom;
            end
            if (i == 200) do_reset();
            cycle();
        end
        clear_inputs();
        for (int j = 0; j < 8; j++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_writeback_arbiter.md
Name: scalar_writeback_arbiter

Overview:
Producer side of the scalar register file write port. It merges scalar results from the single-cycle ALU path and the variable-latency LSU path into one registered write stream (enable/rd/data) per warp. It also keeps a 32-entry pending-write scoreboard so the issue stage can stall on RAW/WAW hazards. Sits between the execute/LSU stages and the register file's write inputs.

Parameters:
DATA_WIDTH, `DATA_WIDTH, width of result data
LSU_FIFO_DEPTH, 4, entries buffering LSU results (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
issue_valid  in  1  issue stage presents an instruction this cycle
issue_write_enable  in  1  instruction writes a scalar rd
issue_rd  in  5  destination register
issue_rs1  in  5  source 1
issue_rs2  in  5  source 2
issue_stall  out  1  hazard; issue must hold the instruction
alu_valid  in  1  ALU result valid (no backpressure)
alu_rd  in  5  ALU destination
alu_data  in  DATA_WIDTH  ALU result
lsu_valid  in  1  LSU result valid
lsu_ready  out  1  LSU result accepted this cycle when valid&ready
lsu_rd  in  5  LSU destination
lsu_data  in  DATA_WIDTH  LSU result
wb_enable  out  1  write strobe to register file
wb_rd  out  5  write address
wb_data  out  DATA_WIDTH  write data
pending_mask  out  32  scoreboard, bit i = write to register i outstanding
idle  out  1  FIFO empty, pending_mask==0, wb_enable==0

Behaviour:
- Reset (async, high): wb_enable=0, wb_rd=0, wb_data=0, pending_mask=0, FIFO empty (pointers 0, count 0), lsu_ready=1, issue_stall=0, idle=1.
- Scoreboard: issue_stall = issue_valid & (pending[rs1] | pending[rs2] | (issue_write_enable & pending[rd])), using registered pending_mask only (no same-cycle bypass). Register 0 is never pending; its bit is always 0.
- Issue accept = issue_valid & ~issue_stall. If accepted, issue_write_enable, and rd!=0, then pending[rd] is set next cycle.
- Selection, each cycle: if alu_valid, the ALU result is selected. Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped. Otherwise, if lsu_valid & FIFO empty, the LSU input passes straight through (bypass) and is not pushed.
- LSU push: lsu_valid & lsu_ready and not bypassed. lsu_ready = FIFO not full. A push and a pop in the same cycle are allowed when full; lsu_ready still reflects the registered count (no comb ready-from-pop path).
- Output register: the selected entry appears on wb_* exactly 1 cycle later. ALU latency is 1. LSU latency is 1 when bypassed, else 1 + queue wait. wb_enable is 0 when nothing is selected; wb_rd/wb_data hold their previous values.
- Results with rd==0 are consumed (popped/accepted) but produce wb_enable=0 and no scoreboard change.
- pending[wb_rd] is cleared in the same edge that drives wb_enable high (clear is on selection). If set (new issue) and clear hit the same rd in the same edge, set wins.
- Ordering: a result for a register that is not pending is still written. No error is raised; a $warning is issued in simulation only.
- Register 31 (execution mask) is treated like any other register.
- FIFO pointers are log2(LSU_FIFO_DEPTH) bits and wrap modulo depth. The count is log2+1 bits.
- Reset mid-operation: all queued LSU results and pending bits are discarded immediately. wb_enable drops asynchronously.

Decomposition:
- Shared package (common.svh): scalar_reg_addr_t (5-bit) and data_t (existing). New: wb_entry_t struct {rd, data}. New constant SCALAR_ZERO_REG=0.
- One sub-module: wb_result_fifo (parameterised depth, wb_entry_t payload, push/pop/full/empty/count, async reset). The arbiter owns selection, the scoreboard and the output register.

Test Plan:
1. Issue rd=5 (write_enable), then alu_valid rd=5 data=0x1234 -> pending_mask[5]=1 after issue; wb_enable=1, wb_rd=5, wb_data=0x1234 one cycle after alu_valid; pending_mask[5]=0 on that same edge.
2. Issue rd=7 pending, then issue rs1=7 -> issue_stall=1 until the rd=7 writeback edge, then 0 the next cycle.
3. alu_valid rd=3 and lsu_valid rd=4 in the same cycle, FIFO empty -> cycle+1 writes rd 3; cycle+2 writes rd 4 from the FIFO; lsu_ready stays 1.
4. alu_valid for 6 consecutive cycles with lsu_valid every cycle (depth 4) -> lsu_ready=0 after 4 pushes; after the ALU stops, 4 LSU writes drain in push order with correct data; idle=1 afterwards.
5. lsu_valid rd=0 data=0xFFFF -> lsu_ready=1, wb_enable stays 0, pending_mask unchanged.
6. 2 entries queued plus pending bits 3,4, then reset pulsed for one cycle -> wb_enable=0 and pending_mask=0 immediately; FIFO empty; idle=1; no later writes of the stale entries.
